// File: rtl/lane_stim_pkg.sv
// Shared types, LFSR definition and pattern constants for the lane stimulus sequencer.
// Pattern bases are 16 bits wide and truncated to the lane width W at use.
package lane_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_LOOP,
        ST_MARKER,
        ST_SPARSE,
        ST_QUIET,
        ST_RAND,
        ST_DONE
    } state_t;

    localparam int                LFSR_W    = 16;
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // All-ones lane (2^W-1): FF at W=8
    localparam logic [15:0] SEED_BASE   = 16'hFFFF;
    localparam logic [15:0] MARKER_BASE = 16'h00BB;
    localparam logic [15:0] SPARSE_VAL  = 16'h0077;
    localparam int          LANE_STEP   = 17;
    localparam int          ROT_STEP    = 3;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] n);
        return (v << n) | (v >> (5'd16 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, loads seed on reset and advances one step per enabled cycle.
// Latency: new value visible the cycle after en; no backpressure, en is a plain step strobe.
// Seed must be a nonzero constant tie-off; the polynomial then never reaches zero.
module lfsr16
    import lane_stim_pkg::*;
(
    input  logic              clk_f,
    input  logic              reset,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/lane_stim_chk.sv
// Multi-lane stimulus sequencer (SEED, LOOP, MARKER, SPARSE, QUIET, RAND) plus dual-output compare checker.
// Latency: all outputs registered, a state's pattern appears in the cycle it is entered; checker counts one cycle later.
// Backpressure: none, free-running; start ignored while busy. STIM_ERR_CAPTURE_EN adds first-error capture ports.
module lane_stim_chk
    import lane_stim_pkg::*;
#(
    parameter int          LANES        = 4,
    parameter int          W            = 8,
    parameter int          LOOP_TIMEOUT = 64,
    parameter int          QUIET_CYCLES = 3,
    parameter int          RAND_CYCLES  = 15,
    parameter int          SPARSE_LANE  = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          CNT_W        = 16
) (
    input  logic                 clk_f,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 idle_in,
    input  logic [LANES*W-1:0]   loop_data_in,
    input  logic [LANES-1:0]     loop_valid_in,
    output logic [LANES*W-1:0]   data_out,
    output logic [LANES-1:0]     valid_out,
    input  logic [W-1:0]         cmp_data_a,
    input  logic [W-1:0]         cmp_data_b,
    input  logic                 cmp_valid_a,
    input  logic                 cmp_valid_b,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     mismatch_cnt
`ifdef STIM_ERR_CAPTURE_EN
    ,
    output logic [31:0]          first_err_cycle,
    output logic [W-1:0]         first_err_a,
    output logic [W-1:0]         first_err_b
`endif
);

    localparam int PH_W = 16;

    state_t               state_q, state_d;
    logic [PH_W-1:0]      ph_q, ph_d;
    logic [LANES*W-1:0]   data_q, data_d;
    logic [LANES-1:0]     valid_q, valid_d;
    logic                 timeout_q, timeout_d;
    logic                 mismatch_q, mismatch_d;
    logic [CNT_W-1:0]     mcnt_q, mcnt_d;
    logic                 lfsr_en;
    logic [LFSR_W-1:0]    lfsr;
    logic                 cmp_diff;

    function automatic logic [W-1:0] pat_lane(input logic [15:0] base, input int i);
        logic [15:0] r;
        r = base - 16'(LANE_STEP * i);
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] lfsr_lane(input logic [15:0] v, input int i);
        logic [15:0] r;
        r = rotl16(v, 4'(ROT_STEP * i));
        return r[W-1:0];
    endfunction

    lfsr16 u_lfsr (
        .clk_f (clk_f),
        .reset (reset),
        .en    (lfsr_en),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    // Phase sequencing; ph_q counts cycles spent in the multi-cycle phases
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_SEED;
            ST_SEED:          state_d = ST_LOOP;
            ST_LOOP: begin
                if (idle_in) begin
                    state_d = ST_MARKER;
                end else if (ph_q == PH_W'(LOOP_TIMEOUT - 1)) begin
                    state_d   = ST_MARKER;
                    timeout_d = 1'b1;
                end
            end
            ST_MARKER:        state_d = ST_SPARSE;
            ST_SPARSE:        state_d = ST_QUIET;
            ST_QUIET:         if (ph_q == PH_W'(QUIET_CYCLES - 1)) state_d = ST_RAND;
            ST_RAND:          if (ph_q == PH_W'(RAND_CYCLES - 1)) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase

        ph_d = '0;
        if ((state_d == state_q) &&
            (state_q == ST_LOOP || state_q == ST_QUIET || state_q == ST_RAND)) begin
            ph_d = ph_q + 1'b1;
        end
    end

    // Pattern for the state being entered, so it lands in the register on entry
    always_comb begin
        data_d  = '0;
        valid_d = '0;
        lfsr_en = 1'b0;
        case (state_d)
            ST_SEED: begin
                for (int i = 0; i < LANES; i++) data_d[i*W +: W] = pat_lane(SEED_BASE, i);
                valid_d = '1;
            end
            ST_LOOP: begin
                data_d  = loop_data_in;
                valid_d = loop_valid_in;
            end
            ST_MARKER: begin
                for (int i = 0; i < LANES; i++) data_d[i*W +: W] = pat_lane(MARKER_BASE, i);
                valid_d = '1;
            end
            ST_SPARSE, ST_QUIET, ST_RAND: begin
                lfsr_en = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    data_d[i*W +: W] = lfsr_lane(lfsr, i);
                    if (state_d == ST_RAND) valid_d[i] = lfsr[LFSR_W-1-i];
                end
                if (state_d == ST_SPARSE) begin
                    data_d[SPARSE_LANE*W +: W] = SPARSE_VAL[W-1:0];
                    valid_d[SPARSE_LANE]       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Checker runs every cycle regardless of the sequencer state
    always_comb begin
        cmp_diff   = (cmp_data_a != cmp_data_b) || (cmp_valid_a != cmp_valid_b);
        mismatch_d = mismatch_q | cmp_diff;
        mcnt_d     = mcnt_q;
        if (cmp_diff && (mcnt_q != '1)) begin
            mcnt_d = mcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ph_q       <= '0;
            data_q     <= '0;
            valid_q    <= '0;
            timeout_q  <= 1'b0;
            mismatch_q <= 1'b0;
            mcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            mismatch_q <= mismatch_d;
            mcnt_q     <= mcnt_d;
        end
    end

    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign timeout      = timeout_q;
    assign mismatch     = mismatch_q;
    assign mismatch_cnt = mcnt_q;

`ifdef STIM_ERR_CAPTURE_EN
    logic [31:0]  cyc_q, cyc_d;
    logic [31:0]  ferr_cyc_q, ferr_cyc_d;
    logic [W-1:0] ferr_a_q, ferr_a_d;
    logic [W-1:0] ferr_b_q, ferr_b_d;

    // mismatch_q low means this is the first differing cycle since reset
    always_comb begin
        cyc_d      = cyc_q + 32'd1;
        ferr_cyc_d = ferr_cyc_q;
        ferr_a_d   = ferr_a_q;
        ferr_b_d   = ferr_b_q;
        if (cmp_diff && !mismatch_q) begin
            ferr_cyc_d = cyc_q;
            ferr_a_d   = cmp_data_a;
            ferr_b_d   = cmp_data_b;
        end
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            cyc_q      <= '0;
            ferr_cyc_q <= '0;
            ferr_a_q   <= '0;
            ferr_b_q   <= '0;
        end else begin
            cyc_q      <= cyc_d;
            ferr_cyc_q <= ferr_cyc_d;
            ferr_a_q   <= ferr_a_d;
            ferr_b_q   <= ferr_b_d;
        end
    end

    assign first_err_cycle = ferr_cyc_q;
    assign first_err_a     = ferr_a_q;
    assign first_err_b     = ferr_b_q;
`endif

endmodule

// File: tb/tb_lane_stim_chk.sv
// Randomized scoreboard bench for lane_stim_chk: the driver predicts each registered output
// from the phase rules and a reference LFSR, a negedge monitor pops and compares.
module tb_lane_stim_chk;

    localparam int          LANES        = 4;
    localparam int          W            = 8;
    localparam int          LOOP_TIMEOUT = 8;
    localparam int          QUIET_CYCLES = 3;
    localparam int          RAND_CYCLES  = 15;
    localparam int          SPARSE_LANE  = 2;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam int          CNT_W        = 4;

    logic                 clk_f = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic                 idle_in = 1'b0;
    logic [LANES*W-1:0]   loop_data_in = '0;
    logic [LANES-1:0]     loop_valid_in = '0;
    logic [LANES*W-1:0]   data_out;
    logic [LANES-1:0]     valid_out;
    logic [W-1:0]         cmp_data_a = '0;
    logic [W-1:0]         cmp_data_b = '0;
    logic                 cmp_valid_a = 1'b0;
    logic                 cmp_valid_b = 1'b0;
    logic                 busy, done, timeout, mismatch;
    logic [CNT_W-1:0]     mismatch_cnt;
`ifdef STIM_ERR_CAPTURE_EN
    logic [31:0]          first_err_cycle;
    logic [W-1:0]         first_err_a, first_err_b;
`endif

    lane_stim_chk #(
        .LANES(LANES), .W(W), .LOOP_TIMEOUT(LOOP_TIMEOUT), .QUIET_CYCLES(QUIET_CYCLES),
        .RAND_CYCLES(RAND_CYCLES), .SPARSE_LANE(SPARSE_LANE), .LFSR_SEED(LFSR_SEED), .CNT_W(CNT_W)
    ) dut (
        .clk_f(clk_f), .reset(reset), .start(start), .idle_in(idle_in),
        .loop_data_in(loop_data_in), .loop_valid_in(loop_valid_in),
        .data_out(data_out), .valid_out(valid_out),
        .cmp_data_a(cmp_data_a), .cmp_data_b(cmp_data_b),
        .cmp_valid_a(cmp_valid_a), .cmp_valid_b(cmp_valid_b),
        .busy(busy), .done(done), .timeout(timeout), .mismatch(mismatch),
        .mismatch_cnt(mismatch_cnt)
`ifdef STIM_ERR_CAPTURE_EN
        , .first_err_cycle(first_err_cycle), .first_err_a(first_err_a), .first_err_b(first_err_b)
`endif
    );

    always #5 clk_f = ~clk_f;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  valid;
        logic        busy;
        logic        done;
        logic        tmo;
        logic        mm;
        int          mcnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] m_lfsr = LFSR_SEED;
    bit          m_tmo = 0;
    bit          m_mm = 0;
    int          m_mcnt = 0;
    bit          m_done = 0;
    bit          cmp_rand = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [W-1:0] lane_rot(input logic [15:0] q, input int i);
        int s = (3 * i) % 16;
        int r;
        r = ((int'(q) << s) | (int'(q) >> (16 - s))) & 32'h0000FFFF;
        return r[W-1:0];
    endfunction

    function automatic logic [31:0] lfsr_word(input logic [15:0] q);
        logic [31:0] w = '0;
        for (int i = 0; i < LANES; i++) w[i*W +: W] = lane_rot(q, i);
        return w;
    endfunction

    // Monitor: one expected entry per clock edge, checked mid-cycle
    initial forever begin
        @(negedge clk_f);
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("data_out", data_out, e.data);
            chk("valid_out", 32'(valid_out), 32'(e.valid));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("timeout", 32'(timeout), 32'(e.tmo));
            chk("mismatch", 32'(mismatch), 32'(e.mm));
            chk("mismatch_cnt", 32'(mismatch_cnt), e.mcnt);
        end
    end

    // One clock edge: predict checker result, then queue the expectation after the edge
    task automatic step(input logic [31:0] d, input logic [3:0] v, input bit b, input bit dn);
        exp_t e;
        if (cmp_rand) begin
            cmp_data_a  = W'($urandom);
            cmp_valid_a = 1'($urandom);
            cmp_data_b  = ($urandom_range(0, 3) == 0) ? W'($urandom) : cmp_data_a;
            cmp_valid_b = ($urandom_range(0, 7) == 0) ? ~cmp_valid_a : cmp_valid_a;
        end
        if (cmp_data_a != cmp_data_b || cmp_valid_a != cmp_valid_b) begin
            m_mm = 1;
            if (m_mcnt < (2 ** CNT_W) - 1) m_mcnt++;
        end
        e.data = d; e.valid = v; e.busy = b; e.done = dn;
        e.tmo = m_tmo; e.mm = m_mm; e.mcnt = m_mcnt;
        @(posedge clk_f);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle_step();
        idle_in = 1'($urandom);
        step(32'h0, 4'h0, 1'b0, m_done);
    endtask

    // idle_at: LOOP cycle (1-based) whose edge sees idle_in=1, 0 = never.
    // abort_rand >= 1 returns while still in RAND after that many RAND cycles.
    task automatic run(input int idle_at, input bit fixed, input int abort_rand);
        logic [31:0] d;
        logic [3:0]  v;
        logic [31:0] w;
        bit          go;
        start   = 1;
        idle_in = 1'($urandom);
        step(32'hCCDDEEFF, 4'hF, 1'b1, 1'b0);
        start  = 0;
        m_done = 0;
        d = fixed ? 32'h78563412 : $urandom;
        v = fixed ? 4'hF : 4'($urandom);
        loop_data_in = d; loop_valid_in = v; idle_in = 1'($urandom);
        step(d, v, 1'b1, 1'b0);
        go = 1;
        for (int k = 1; go; k++) begin
            d = fixed ? 32'h78563412 : $urandom;
            v = fixed ? 4'hF : 4'($urandom);
            loop_data_in = d; loop_valid_in = v;
            idle_in = (k == idle_at);
            start   = (k == 2);
            if (idle_in || k == LOOP_TIMEOUT) begin
                if (!idle_in) m_tmo = 1;
                step(32'h8899AABB, 4'hF, 1'b1, 1'b0);
                go = 0;
            end else begin
                step(d, v, 1'b1, 1'b0);
            end
        end
        start = 0;
        idle_in = 1'($urandom);
        w = lfsr_word(m_lfsr);
        w[SPARSE_LANE*W +: W] = 8'h77;
        step(w, 4'b0100, 1'b1, 1'b0);
        m_lfsr = lfsr_next(m_lfsr);
        for (int q = 0; q < QUIET_CYCLES; q++) begin
            idle_in = 1'($urandom);
            step(lfsr_word(m_lfsr), 4'h0, 1'b1, 1'b0);
            m_lfsr = lfsr_next(m_lfsr);
        end
        for (int r = 0; r < RAND_CYCLES; r++) begin
            if (r == abort_rand) return;
            start = 1'($urandom);
            for (int i = 0; i < LANES; i++) v[i] = m_lfsr[15 - i];
            step(lfsr_word(m_lfsr), v, 1'b1, 1'b0);
            m_lfsr = lfsr_next(m_lfsr);
        end
        start = 0;
        step(32'h0, 4'h0, 1'b0, 1'b1);
        m_done = 1;
    endtask

    initial begin
        repeat (10) @(posedge clk_f);
        @(negedge clk_f);
        chk("rst data_out", data_out, 32'h0);
        chk("rst valid_out", 32'(valid_out), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst timeout", 32'(timeout), 32'h0);
        chk("rst mismatch", 32'(mismatch), 32'h0);
        chk("rst mismatch_cnt", 32'(mismatch_cnt), 32'h0);
        reset = 1;

        // Directed compare: three differing cycles then equal
        idle_step(); idle_step();
        cmp_data_a = 8'h10; cmp_data_b = 8'h11;
        repeat (3) idle_step();
        cmp_data_b = 8'h10;
        repeat (2) idle_step();
`ifdef STIM_ERR_CAPTURE_EN
        chk("first_err_cycle", first_err_cycle, 32'd2);
        chk("first_err_a", 32'(first_err_a), 32'h10);
        chk("first_err_b", 32'(first_err_b), 32'h11);
`endif
        cmp_rand = 1;

        run(5, 1'b1, -1);
        idle_step(); idle_step();
        run(LOOP_TIMEOUT, 1'b0, -1);
        idle_step();
        run(0, 1'b0, -1);
        for (int n = 0; n < 3; n++) begin
            idle_step();
            run($urandom_range(0, 10), 1'b0, -1);
        end
        idle_step();
        run(3, 1'b0, 6);

        // Reset lands mid-cycle while in RAND; outputs must drop immediately
        @(negedge clk_f);
        #1 reset = 0;
        #1;
        chk("abort data_out", data_out, 32'h0);
        chk("abort valid_out", 32'(valid_out), 32'h0);
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort timeout", 32'(timeout), 32'h0);
        chk("abort mismatch_cnt", 32'(mismatch_cnt), 32'h0);
        m_lfsr = LFSR_SEED; m_tmo = 0; m_mm = 0; m_mcnt = 0; m_done = 0;
        repeat (3) @(posedge clk_f);
        @(negedge clk_f);
        reset = 1;
        #1;
        idle_step(); idle_step();
        run(4, 1'b0, -1);
        idle_step(); idle_step();

        for (int g = 0; g < 20 && exp_q.size() > 0; g++) @(negedge clk_f);
        chk("scoreboard drain", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lane_stim_chk.md
Name: lane_stim_chk

Overview:
Synthesizable, parametrised multi-lane stimulus sequencer and dual-output checker for the byte-striping mux/demux chain. Drives LANES parallel data/valid lanes into the DUT through a fixed phase sequence: seed, loopback of the received lanes until link idle, marker, sparse lane, quiet, pseudo-random. In parallel it compares two DUT output copies (behavioural vs synthesized) every cycle and counts mismatches. Sits beside the DUT on the clk_f domain.

Parameters:
LANES, 4, number of parallel lanes (1..8)
W, 8, lane data width in bits (8..16)
LOOP_TIMEOUT, 64, maximum LOOP cycles before forced exit
QUIET_CYCLES, 3, cycles of all-invalid random data after SPARSE
RAND_CYCLES, 15, cycles of LFSR-driven data/valid
SPARSE_LANE, 2, lane index driven valid in SPARSE
LFSR_SEED, 16'hACE1, nonzero LFSR reset value
CNT_W, 16, mismatch counter width

Ports:
clk_f  in  1  single clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; starts the sequence from IDLE or DONE
idle_in  in  1  DUT link-idle indication
loop_data_in  in  LANES*W  received lane data to replay; lane i at [i*W +: W]
loop_valid_in  in  LANES  received lane valids
data_out  out  LANES*W  stimulus data, registered
valid_out  out  LANES  stimulus valids, registered
cmp_data_a / cmp_data_b  in  W  the two DUT output copies to compare
cmp_valid_a / cmp_valid_b  in  1  valids of the two copies
busy  out  1  high in any state other than IDLE and DONE
done  out  1  high in DONE
timeout  out  1  sticky; LOOP exited by timeout
mismatch  out  1  sticky; any compare mismatch since reset
mismatch_cnt  out  CNT_W  saturating mismatch count

Behaviour:
- Reset (async, reset=0): state IDLE. data_out=0, valid_out=0, busy=0, done=0, timeout=0, mismatch=0, mismatch_cnt=0, LFSR=LFSR_SEED, phase counter=0.
- States: IDLE, SEED, LOOP, MARKER, SPARSE, QUIET, RAND, DONE. All outputs are registered, so values for a state appear in the cycle that state is entered.
- IDLE/DONE: start=1 -> SEED. Outputs are 0. start is ignored while busy.
- SEED, 1 cycle: lane i data = (2^W-1) - 17*i mod 2^W, i.e. FF,EE,DD,CC at W=8. All valid=1. Next state LOOP.
- LOOP: each cycle data_out<=loop_data_in and valid_out<=loop_valid_in. If idle_in=1 at a clock edge -> MARKER. Otherwise, when the counter reaches LOOP_TIMEOUT-1 -> MARKER and set timeout. idle_in has priority when both occur in the same cycle, and timeout is not set.
- MARKER, 1 cycle: lane i = (0xBB - 17*i) mod 2^W (BB,AA,99,88), all valid.
- SPARSE, 1 cycle: lane SPARSE_LANE = 0x77, valid only on that lane. Other lanes carry LFSR data with valid=0.
- QUIET: QUIET_CYCLES cycles of LFSR data, valid_out=0.
- RAND: RAND_CYCLES cycles. Lane i data = low W bits of LFSR rotated left by 3*i. valid[i] = LFSR[15-i].
- After RAND -> DONE, done=1.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Steps once per cycle in SPARSE, QUIET and RAND only. Never reaches zero.
- Checker: active every cycle while reset=1, independent of state. A mismatch is (cmp_data_a!=cmp_data_b) or (cmp_valid_a!=cmp_valid_b). On mismatch, mismatch_cnt increments, holding at 2^CNT_W-1, and mismatch is set. Neither clears except on reset.
- Reset asserted mid-sequence: immediate return to reset values. start is required to rerun.
- start arriving in DONE: restarts at SEED. The LFSR is not reseeded, so successive runs differ. timeout and mismatch are unchanged.

Optional Feature:
STIM_ERR_CAPTURE_EN
- Defined: adds outputs first_err_cycle[31:0], first_err_a[W-1:0] and first_err_b[W-1:0]. A free-running cycle counter starts at reset release. On the first mismatch after reset, the counter value and both data values are captured and then held until reset.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package lane_stim_pkg: state enum, LFSR taps and width (16), pattern constants (SEED_BASE 0xFF, MARKER_BASE 0xBB, SPARSE_VAL 0x77, LANE_STEP 17), rotate amount 3.
- Sub-module lfsr16 (clk_f, reset, en, seed -> q): reused by other benches in the chain.
- Checker kept inline.

Test Plan:
- Reset held 10 cycles, release, start pulse -> first cycle after start: data_out FF,EE,DD,CC, valid 4'hF, busy=1.
- Loop data 0x12,0x34,0x56,0x78, idle_in rises after 5 LOOP cycles -> 5 cycles of replayed data, then BB,AA,99,88, then only lane 2 = 0x77 valid.
- idle_in held 0 with LOOP_TIMEOUT=8 -> exactly 8 LOOP cycles, then MARKER, timeout=1.
- After SPARSE -> 3 cycles valid=0, then 15 RAND cycles matching a reference LFSR model from 16'hACE1, then done=1 with outputs zero.
- cmp_data_a=0x10, cmp_data_b=0x11 for 3 cycles, then equal -> mismatch_cnt=3, mismatch=1 sticky. With STIM_ERR_CAPTURE_EN, first_err_a=0x10 and first_err_b=0x11.
- Reset asserted during RAND -> outputs 0 and IDLE in the same cycle. start ignored while busy, and a start pulse mid-LOOP has no effect.
